// File: rtl/tube_display_arbiter.sv
// Arbitrates the 8-digit seven-segment display between three requesters (2 > 1 > 0),
// snapshots the owner's frame at scan-frame boundaries and drives the digit scan.
module tube_display_arbiter #(
   parameter int unsigned SCAN_DIV        = 100000,
   parameter int unsigned MIN_HOLD_FRAMES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  req_i,
   input  logic [63:0] frame0_i,
   input  logic [63:0] frame1_i,
   input  logic [63:0] frame2_i,
   output logic [2:0]  grant_o,
   output logic        frame_start_o,
   output logic [7:0]  seg_en_o,
   output logic [7:0]  tube1_o,
   output logic [7:0]  tube2_o
);

   localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [0:0] {StIdle, StOwn} state_e;

   state_e          state_q, state_d;
   logic [1:0]      owner_q, owner_d;
   logic [7:0]      hold_q, hold_d;
   logic [63:0]     snap_q, snap_d;
   logic [2:0]      grant_q, grant_d;
   logic [DivW-1:0] div_cnt_q;
   logic [2:0]      scan_idx_q;
   logic [7:0]      seg_en_q, tube1_q, tube2_q;
   logic            frame_start_q;

   logic            tick, boundary;
   logic [1:0]      high_idx;
   logic [8:0]      hold_inc;
   logic [2:0]      new_idx;
   logic [63:0]     disp;
   logic [7:0]      chr;

   assign tick     = (div_cnt_q == DivW'(SCAN_DIV - 1));
   assign boundary = tick && (scan_idx_q == 3'd7);
   assign hold_inc = {1'b0, hold_q} + 9'd1;

   always_comb begin
      high_idx = 2'd0;
      if (req_i[2]) begin
         high_idx = 2'd2;
      end else if (req_i[1]) begin
         high_idx = 2'd1;
      end
   end

   // Ownership decision, only committed on a frame boundary.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      hold_d  = hold_q;
      unique case (state_q)
         StIdle: begin
            if (|req_i) begin
               state_d = StOwn;
               owner_d = high_idx;
               hold_d  = 8'd0;
            end
         end
         StOwn: begin
            if (|req_i && (high_idx > owner_q)) begin
               owner_d = high_idx;
               hold_d  = 8'd0;
            end else if (|(req_i & grant_q)) begin
               hold_d = (hold_q == 8'hFF) ? 8'hFF : hold_inc[7:0];
            end else if (hold_inc < 9'(MIN_HOLD_FRAMES)) begin
               hold_d = hold_inc[7:0];
            end else if (|req_i) begin
               owner_d = high_idx;
               hold_d  = 8'd0;
            end else begin
               state_d = StIdle;
               hold_d  = 8'd0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      grant_d = 3'b000;
      snap_d  = 64'd0;
      if (state_d == StOwn) begin
         grant_d = 3'b001 << owner_d;
         unique case (owner_d)
            2'd0:    snap_d = frame0_i;
            2'd1:    snap_d = frame1_i;
            default: snap_d = frame2_i;
         endcase
      end
   end

   // Digit 0 of a new frame bypasses the snapshot register.
   assign new_idx = scan_idx_q + 3'd1;
   assign disp    = boundary ? snap_d : snap_q;
   assign chr     = disp[{new_idx, 3'b000} +: 8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q     <= '0;
         scan_idx_q    <= 3'd0;
         state_q       <= StIdle;
         owner_q       <= 2'd0;
         hold_q        <= 8'd0;
         snap_q        <= 64'd0;
         grant_q       <= 3'b000;
         seg_en_q      <= 8'h00;
         tube1_q       <= 8'h00;
         tube2_q       <= 8'h00;
         frame_start_q <= 1'b0;
      end else begin
         div_cnt_q     <= tick ? '0 : div_cnt_q + 1'b1;
         frame_start_q <= boundary;
         if (tick) begin
            scan_idx_q <= new_idx;
            seg_en_q   <= 8'h01 << new_idx;
            tube1_q    <= new_idx[2] ? 8'h00 : chr;
            tube2_q    <= new_idx[2] ? chr : 8'h00;
         end
         if (boundary) begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            snap_q  <= snap_d;
            grant_q <= grant_d;
         end
      end
   end

   assign grant_o       = grant_q;
   assign frame_start_o = frame_start_q;
   assign seg_en_o      = seg_en_q;
   assign tube1_o       = tube1_q;
   assign tube2_o       = tube2_q;

endmodule
